// File: rtl/reorder_retire.sv
// In-order retirement buffer for renamed destinations: records rename allocations,
// retires completed entries to the free list and walks squashed entries back on flush.
module reorder_retire #(
  parameter int unsigned VREG_WIDTH = 5,
  parameter int unsigned PREG_WIDTH = 6,
  parameter int unsigned ROB_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_valid_i,
  input  logic [VREG_WIDTH-1:0] alloc_vreg_i,
  input  logic [PREG_WIDTH-1:0] alloc_old_preg_i,
  input  logic [PREG_WIDTH-1:0] alloc_new_preg_i,
  output logic                  alloc_ready_o,
  output logic [ROB_WIDTH-1:0]  alloc_index_o,
  input  logic                  wb_valid_i,
  input  logic [ROB_WIDTH-1:0]  wb_index_i,
  output logic                  retire_valid_o,
  output logic [VREG_WIDTH-1:0] retire_vreg_o,
  output logic [PREG_WIDTH-1:0] retire_new_preg_o,
  output logic [PREG_WIDTH-1:0] free_preg_o,
  input  logic                  free_ready_i,
  input  logic                  flush_valid_i,
  input  logic [ROB_WIDTH-1:0]  flush_index_i,
  output logic                  restore_valid_o,
  output logic [VREG_WIDTH-1:0] restore_vreg_o,
  output logic [PREG_WIDTH-1:0] restore_old_preg_o,
  output logic [PREG_WIDTH-1:0] restore_new_preg_o,
  output logic                  busy_o
);

  localparam int unsigned Depth = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FullCount = (ROB_WIDTH + 1)'(Depth);
  localparam logic [0:0] StIdle     = 1'b0;
  localparam logic [0:0] StRollback = 1'b1;

  logic [Depth-1:0]      valid_q, valid_d, done_q, done_d;
  logic [VREG_WIDTH-1:0] vreg_q [Depth];
  logic [VREG_WIDTH-1:0] vreg_d [Depth];
  logic [PREG_WIDTH-1:0] old_q  [Depth];
  logic [PREG_WIDTH-1:0] old_d  [Depth];
  logic [PREG_WIDTH-1:0] new_q  [Depth];
  logic [PREG_WIDTH-1:0] new_d  [Depth];
  logic [ROB_WIDTH-1:0]  head_q, head_d, tail_q, tail_d, stop_q, stop_d;
  logic [ROB_WIDTH:0]    count_q, count_d;
  logic [0:0]            state_q, state_d;

  logic                 is_idle, rolling, flush_take, alloc_fire, retire_fire;
  logic [ROB_WIDTH-1:0] tail_m1, stop_p1;

  assign is_idle = (state_q == StIdle);
  assign rolling = (state_q == StRollback);
  assign tail_m1 = tail_q - 1'b1;
  assign stop_p1 = stop_q + 1'b1;

  assign flush_take  = is_idle && flush_valid_i && (count_q != '0) && (flush_index_i != tail_m1);
  assign alloc_ready_o = is_idle && (count_q != FullCount);
  // Any flush request in IDLE drops a coincident allocation.
  assign alloc_fire  = alloc_valid_i && alloc_ready_o && !flush_valid_i;
  assign retire_fire = is_idle && !flush_take && valid_q[head_q] && done_q[head_q] && free_ready_i;

  assign alloc_index_o      = tail_q;
  assign retire_valid_o     = retire_fire;
  assign retire_vreg_o      = retire_fire ? vreg_q[head_q] : '0;
  assign retire_new_preg_o  = retire_fire ? new_q[head_q] : '0;
  assign free_preg_o        = retire_fire ? old_q[head_q] : '0;
  assign restore_valid_o    = rolling;
  assign restore_vreg_o     = rolling ? vreg_q[tail_q] : '0;
  assign restore_old_preg_o = rolling ? old_q[tail_q] : '0;
  assign restore_new_preg_o = rolling ? new_q[tail_q] : '0;
  assign busy_o             = rolling;

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    vreg_d  = vreg_q;
    old_d   = old_q;
    new_d   = new_q;
    head_d  = head_q;
    tail_d  = tail_q;
    stop_d  = stop_q;
    count_d = count_q;
    state_d = state_q;

    if (wb_valid_i && valid_q[wb_index_i]) begin
      done_d[wb_index_i] = 1'b1;
    end
    if (retire_fire) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      vreg_d[tail_q]  = alloc_vreg_i;
      old_d[tail_q]   = alloc_old_preg_i;
      new_d[tail_q]   = alloc_new_preg_i;
      tail_d          = tail_q + 1'b1;
    end
    if (flush_take) begin
      tail_d  = tail_m1;
      stop_d  = flush_index_i;
      state_d = StRollback;
    end
    // tail_q points at the youngest surviving-or-not entry being walked back.
    if (rolling) begin
      valid_d[tail_q] = 1'b0;
      done_d[tail_q]  = 1'b0;
      if (tail_q == stop_p1) begin
        state_d = StIdle;
      end else begin
        tail_d = tail_m1;
      end
    end

    unique case ({alloc_fire, retire_fire || rolling})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      done_q  <= '0;
      vreg_q  <= '{default: '0};
      old_q   <= '{default: '0};
      new_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      stop_q  <= '0;
      count_q <= '0;
      state_q <= StIdle;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      vreg_q  <= vreg_d;
      old_q   <= old_d;
      new_q   <= new_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      stop_q  <= stop_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_reorder_retire.sv
// Directed bench for reorder_retire: in-order retire, full, backpressure, flush walk,
// pointer wrap and asynchronous reset during rollback.
module tb_reorder_retire;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_valid_i;
  logic [4:0] alloc_vreg_i;
  logic [5:0] alloc_old_preg_i, alloc_new_preg_i;
  logic       alloc_ready_o;
  logic [4:0] alloc_index_o;
  logic       wb_valid_i;
  logic [4:0] wb_index_i;
  logic       retire_valid_o;
  logic [4:0] retire_vreg_o;
  logic [5:0] retire_new_preg_o, free_preg_o;
  logic       free_ready_i;
  logic       flush_valid_i;
  logic [4:0] flush_index_i;
  logic       restore_valid_o;
  logic [4:0] restore_vreg_o;
  logic [5:0] restore_old_preg_o, restore_new_preg_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  reorder_retire dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .alloc_valid_i     (alloc_valid_i),
    .alloc_vreg_i      (alloc_vreg_i),
    .alloc_old_preg_i  (alloc_old_preg_i),
    .alloc_new_preg_i  (alloc_new_preg_i),
    .alloc_ready_o     (alloc_ready_o),
    .alloc_index_o     (alloc_index_o),
    .wb_valid_i        (wb_valid_i),
    .wb_index_i        (wb_index_i),
    .retire_valid_o    (retire_valid_o),
    .retire_vreg_o     (retire_vreg_o),
    .retire_new_preg_o (retire_new_preg_o),
    .free_preg_o       (free_preg_o),
    .free_ready_i      (free_ready_i),
    .flush_valid_i     (flush_valid_i),
    .flush_index_i     (flush_index_i),
    .restore_valid_o   (restore_valid_o),
    .restore_vreg_o    (restore_vreg_o),
    .restore_old_preg_o(restore_old_preg_o),
    .restore_new_preg_o(restore_new_preg_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    alloc_valid_i = 0; alloc_vreg_i = 0; alloc_old_preg_i = 0; alloc_new_preg_i = 0;
    wb_valid_i = 0; wb_index_i = 0; free_ready_i = 1; flush_valid_i = 0; flush_index_i = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
  endtask

  task automatic alloc(input logic [4:0] v, input logic [5:0] o, input logic [5:0] n);
    alloc_valid_i = 1; alloc_vreg_i = v; alloc_old_preg_i = o; alloc_new_preg_i = n;
    tick();
    alloc_valid_i = 0;
  endtask

  task automatic wb(input logic [4:0] idx);
    wb_valid_i = 1; wb_index_i = idx;
    tick();
    wb_valid_i = 0;
  endtask

  task automatic test_reset();
    alloc_valid_i = 0; wb_valid_i = 0; flush_valid_i = 0; free_ready_i = 1;
    rst_n = 0;
    #2;
    checks++;
    if ({alloc_ready_o, alloc_index_o, retire_valid_o, free_preg_o, restore_valid_o, busy_o}
        !== {1'b1, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got ready=%0b idx=%0d ret=%0b free=%0d rst=%0b busy=%0b",
               alloc_ready_o, alloc_index_o, retire_valid_o, free_preg_o, restore_valid_o,
               busy_o);
    end
    tick();
    rst_n = 1;
    #1;
  endtask

  task automatic test_in_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (alloc_index_o !== 5'(i)) begin
        errors++; $display("FAIL inorder_alloc_index got %0d exp %0d", alloc_index_o, i);
      end
      alloc(5'(i + 1), 6'(i + 1), 6'(32 + i));
    end
    wb(5'd2);
    checks++;
    if (retire_valid_o !== 1'b0) begin
      errors++; $display("FAIL inorder_no_early_retire got %0b exp 0", retire_valid_o);
    end
    wb(5'd0);
    wb_valid_i = 1; wb_index_i = 5'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({retire_valid_o, retire_vreg_o, free_preg_o, retire_new_preg_o} !==
          {1'b1, 5'(i + 1), 6'(i + 1), 6'(32 + i)}) begin
        errors++;
        $display("FAIL inorder_retire%0d got v=%0b vreg=%0d free=%0d new=%0d exp 1 %0d %0d %0d",
                 i, retire_valid_o, retire_vreg_o, free_preg_o, retire_new_preg_o,
                 i + 1, i + 1, 32 + i);
      end
      tick();
      wb_valid_i = 0;
    end
    checks++;
    if (retire_valid_o !== 1'b0) begin
      errors++; $display("FAIL inorder_empty_after got %0b exp 0", retire_valid_o);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      if (alloc_ready_o !== 1'b1) begin
        checks++; errors++;
        $display("FAIL full_ready_early at %0d got 0 exp 1", i);
      end
      alloc(5'(i), 6'(i), 6'(i + 32));
    end
    checks++;
    if ({alloc_ready_o, alloc_index_o} !== {1'b0, 5'd0}) begin
      errors++;
      $display("FAIL full_ready got %0b idx %0d exp 0 0", alloc_ready_o, alloc_index_o);
    end
    alloc(5'd31, 6'd63, 6'd63);
    checks++;
    if ({alloc_ready_o, alloc_index_o} !== {1'b0, 5'd0}) begin
      errors++;
      $display("FAIL full_drop got %0b idx %0d exp 0 0", alloc_ready_o, alloc_index_o);
    end
    wb(5'd0);
    checks++;
    if ({retire_valid_o, free_preg_o, retire_new_preg_o} !== {1'b1, 6'd0, 6'd32}) begin
      errors++;
      $display("FAIL full_entry0_kept got %0b free %0d new %0d exp 1 0 32",
               retire_valid_o, free_preg_o, retire_new_preg_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    alloc(5'd7, 6'd9, 6'd20);
    free_ready_i = 0;
    wb(5'd0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (retire_valid_o !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle %0d got %0b exp 0", i, retire_valid_o);
      end
      tick();
    end
    free_ready_i = 1;
    #1;
    checks++;
    if ({retire_valid_o, retire_vreg_o, free_preg_o} !== {1'b1, 5'd7, 6'd9}) begin
      errors++;
      $display("FAIL bp_release got %0b vreg %0d free %0d exp 1 7 9",
               retire_valid_o, retire_vreg_o, free_preg_o);
    end
    tick();
    checks++;
    if (retire_valid_o !== 1'b0) begin
      errors++; $display("FAIL bp_single_retire got %0b exp 0", retire_valid_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 6; i++) alloc(5'(i), 6'(10 + i), 6'(40 + i));
    flush_valid_i = 1; flush_index_i = 5'd1;
    alloc_valid_i = 1;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL flush_busy_same_cycle got %0b exp 0", busy_o);
    end
    tick();
    flush_valid_i = 0; alloc_valid_i = 0;
    for (int k = 5; k >= 2; k--) begin
      checks++;
      if ({busy_o, restore_valid_o, restore_vreg_o, restore_old_preg_o, restore_new_preg_o,
           alloc_ready_o} !== {1'b1, 1'b1, 5'(k), 6'(10 + k), 6'(40 + k), 1'b0}) begin
        errors++;
        $display("FAIL flush_restore%0d got busy=%0b v=%0b vreg=%0d old=%0d new=%0d rdy=%0b",
                 k, busy_o, restore_valid_o, restore_vreg_o, restore_old_preg_o,
                 restore_new_preg_o, alloc_ready_o);
      end
      tick();
    end
    checks++;
    if ({busy_o, restore_valid_o, alloc_ready_o, alloc_index_o} !==
        {1'b0, 1'b0, 1'b1, 5'd2}) begin
      errors++;
      $display("FAIL flush_done got busy=%0b v=%0b rdy=%0b idx=%0d exp 0 0 1 2",
               busy_o, restore_valid_o, alloc_ready_o, alloc_index_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 31; i++) alloc(5'(i), 6'(i), 6'(i));
    wb(5'd0);
    checks++;
    if ({retire_valid_o, alloc_ready_o, alloc_index_o} !== {1'b1, 1'b1, 5'd31}) begin
      errors++;
      $display("FAIL wrap_pre got ret=%0b rdy=%0b idx=%0d exp 1 1 31",
               retire_valid_o, alloc_ready_o, alloc_index_o);
    end
    alloc(5'd3, 6'd50, 6'd51);
    checks++;
    if ({alloc_ready_o, alloc_index_o} !== {1'b1, 5'd0}) begin
      errors++;
      $display("FAIL wrap_tail got rdy=%0b idx=%0d exp 1 0", alloc_ready_o, alloc_index_o);
    end
    alloc(5'd4, 6'd52, 6'd53);
    checks++;
    if ({alloc_ready_o, alloc_index_o} !== {1'b0, 5'd1}) begin
      errors++;
      $display("FAIL wrap_count got rdy=%0b idx=%0d exp 0 1", alloc_ready_o, alloc_index_o);
    end
  endtask

  task automatic test_reset_mid_rollback();
    do_reset();
    for (int i = 0; i < 6; i++) alloc(5'(i), 6'(10 + i), 6'(40 + i));
    flush_valid_i = 1; flush_index_i = 5'd1;
    tick();
    flush_valid_i = 0;
    tick();
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL rbreset_pre got busy %0b exp 1", busy_o);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({busy_o, restore_valid_o, restore_vreg_o, alloc_ready_o, alloc_index_o, retire_valid_o}
        !== {1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL rbreset_outputs got busy=%0b v=%0b vreg=%0d rdy=%0b idx=%0d ret=%0b",
               busy_o, restore_valid_o, restore_vreg_o, alloc_ready_o, alloc_index_o,
               retire_valid_o);
    end
    tick();
    rst_n = 1;
    tick();
    checks++;
    if ({busy_o, alloc_index_o} !== {1'b0, 5'd0}) begin
      errors++;
      $display("FAIL rbreset_after got busy=%0b idx=%0d exp 0 0", busy_o, alloc_index_o);
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_backpressure();
    test_flush();
    test_wrap();
    test_reset_mid_rollback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
